// File: rtl/im_loader_if.sv
// Byte-stream, instruction-memory write port and status signals of the program loader.
// The slave modport is the loader; the master modport is the byte source / system side.
interface im_loader_if;
  logic        START;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VALID;
  logic        BYTE_READY;
  logic [15:0] IM_WADDR;
  logic [31:0] IM_WDATA;
  logic        IM_WE;
  logic        CPU_RST_F;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  modport master (
    output START,
    output BYTE_IN,
    output BYTE_VALID,
    input  BYTE_READY,
    input  IM_WADDR,
    input  IM_WDATA,
    input  IM_WE,
    input  CPU_RST_F,
    input  BUSY,
    input  DONE,
    input  ERR
  );

  modport slave (
    input  START,
    input  BYTE_IN,
    input  BYTE_VALID,
    output BYTE_READY,
    output IM_WADDR,
    output IM_WDATA,
    output IM_WE,
    output CPU_RST_F,
    output BUSY,
    output DONE,
    output ERR
  );
endinterface

// File: rtl/im_loader.sv
// Framed byte-stream loader: header word count, big-endian data words written to
// instruction memory, trailing checksum; releases the core reset only on success.
module im_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd1024
) (
  input  logic         CLK,
  input  logic         RST,
  im_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    CKSUM,
    OK,
    FAIL
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] n_reg, n_next;
  logic [15:0] widx_reg, widx_next;
  logic [1:0]  bidx_reg, bidx_next;
  logic [7:0]  ck_reg, ck_next;
  logic [23:0] asm_reg, asm_next;
  logic        ready_reg, ready_next;
  logic [15:0] waddr_reg, waddr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        we_reg, we_next;
  logic        cpu_rst_f_reg, cpu_rst_f_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  logic        xfer;
  logic [15:0] hdr_n;
  logic        last_word;

  // Ready is registered, so acceptance never depends combinationally on valid.
  assign xfer      = bus.BYTE_VALID && ready_reg;
  assign hdr_n     = {n_reg[15:8], bus.BYTE_IN};
  assign last_word = (widx_reg == (n_reg - 16'd1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      n_reg         <= '0;
      widx_reg      <= '0;
      bidx_reg      <= '0;
      ck_reg        <= '0;
      asm_reg       <= '0;
      ready_reg     <= 1'b0;
      waddr_reg     <= BASE_ADDR;
      wdata_reg     <= '0;
      we_reg        <= 1'b0;
      cpu_rst_f_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      n_reg         <= n_next;
      widx_reg      <= widx_next;
      bidx_reg      <= bidx_next;
      ck_reg        <= ck_next;
      asm_reg       <= asm_next;
      ready_reg     <= ready_next;
      waddr_reg     <= waddr_next;
      wdata_reg     <= wdata_next;
      we_reg        <= we_next;
      cpu_rst_f_reg <= cpu_rst_f_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    n_next         = n_reg;
    widx_next      = widx_reg;
    bidx_next      = bidx_reg;
    ck_next        = ck_reg;
    asm_next       = asm_reg;
    ready_next     = ready_reg;
    waddr_next     = waddr_reg;
    wdata_next     = wdata_reg;
    we_next        = 1'b0;
    cpu_rst_f_next = cpu_rst_f_reg;
    busy_next      = busy_reg;
    done_next      = done_reg;
    err_next       = err_reg;

    case (state_reg)
      IDLE, OK, FAIL: begin
        if (bus.START) begin
          state_next     = HDR_HI;
          widx_next      = '0;
          bidx_next      = '0;
          ck_next        = '0;
          ready_next     = 1'b1;
          busy_next      = 1'b1;
          done_next      = 1'b0;
          err_next       = 1'b0;
          cpu_rst_f_next = 1'b0;
        end
      end

      HDR_HI: begin
        if (xfer) begin
          n_next[15:8] = bus.BYTE_IN;
          state_next   = HDR_LO;
        end
      end

      HDR_LO: begin
        if (xfer) begin
          n_next = hdr_n;
          if ((hdr_n == 16'd0) || (hdr_n > MAX_WORDS)) begin
            state_next = FAIL;
            ready_next = 1'b0;
            busy_next  = 1'b0;
            err_next   = 1'b1;
          end else begin
            state_next = DATA;
          end
        end
      end

      DATA: begin
        if (xfer) begin
          ck_next   = ck_reg + bus.BYTE_IN;
          asm_next  = {asm_reg[15:0], bus.BYTE_IN};
          bidx_next = bidx_reg + 2'd1;
          // Fourth byte of a word completes it: launch the write the same edge.
          if (bidx_reg == 2'd3) begin
            wdata_next = {asm_reg, bus.BYTE_IN};
            waddr_next = BASE_ADDR + widx_reg;
            we_next    = 1'b1;
            widx_next  = widx_reg + 16'd1;
            if (last_word) begin
              state_next = CKSUM;
            end
          end
        end
      end

      CKSUM: begin
        if (xfer) begin
          ready_next = 1'b0;
          busy_next  = 1'b0;
          if (bus.BYTE_IN == ck_reg) begin
            state_next     = OK;
            done_next      = 1'b1;
            cpu_rst_f_next = 1'b1;
          end else begin
            state_next = FAIL;
            err_next   = 1'b1;
          end
        end
      end

      default: begin
        state_next     = IDLE;
        ready_next     = 1'b0;
        busy_next      = 1'b0;
        cpu_rst_f_next = 1'b0;
      end
    endcase
  end

  assign bus.BYTE_READY = ready_reg;
  assign bus.IM_WADDR   = waddr_reg;
  assign bus.IM_WDATA   = wdata_reg;
  assign bus.IM_WE      = we_reg;
  assign bus.CPU_RST_F  = cpu_rst_f_reg;
  assign bus.BUSY       = busy_reg;
  assign bus.DONE       = done_reg;
  assign bus.ERR        = err_reg;

endmodule

// File: tb/tb_im_loader.sv
// Directed frame vectors against two loader instances (base 0x0000 and 0xFFFF)
// sharing one stimulus stream; writes are captured by a monitor and compared.
module tb_im_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] byte_in;
  logic       valid;
  logic       sel;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  im_loader_if b0 ();
  im_loader_if b1 ();

  assign b0.START = start;  assign b0.BYTE_IN = byte_in;  assign b0.BYTE_VALID = valid;
  assign b1.START = start;  assign b1.BYTE_IN = byte_in;  assign b1.BYTE_VALID = valid;

  im_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(16'd1024)) dut0 (.CLK(clk), .RST(rst), .bus(b0));
  im_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(16'd1024)) dut1 (.CLK(clk), .RST(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        m_ready, m_we, m_cpu, m_busy, m_done, m_err;
  logic [15:0] m_waddr;
  logic [31:0] m_wdata;
  assign m_ready = sel ? b1.BYTE_READY : b0.BYTE_READY;
  assign m_we    = sel ? b1.IM_WE      : b0.IM_WE;
  assign m_cpu   = sel ? b1.CPU_RST_F  : b0.CPU_RST_F;
  assign m_busy  = sel ? b1.BUSY       : b0.BUSY;
  assign m_done  = sel ? b1.DONE       : b0.DONE;
  assign m_err   = sel ? b1.ERR        : b0.ERR;
  assign m_waddr = sel ? b1.IM_WADDR   : b0.IM_WADDR;
  assign m_wdata = sel ? b1.IM_WDATA   : b0.IM_WDATA;

  logic [15:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];

  always @(negedge clk) begin
    if (m_we) begin
      wq_addr.push_back(m_waddr);
      wq_data.push_back(m_wdata);
      wq_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic               sel;
    int                 len;
    logic [0:10][7:0]   b;
    int                 gap;
    int                 mid_start;  // byte index before which a stray START is pulsed, -1 none
    int                 nw;
    logic [15:0]        a0, a1;
    logic [31:0]        d0, d1;
    logic               done;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pre_ck);
    int w;
    @(negedge clk);
    byte_in = b;
    valid   = 1'b1;
    w = 0;
    while (!m_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      chk("ready_timeout", 32'(m_ready), 32'd1);
      valid = 1'b0;
    end else begin
      if (pre_ck) begin
        chk("cpu_rst_f_before_ck", 32'(m_cpu), 32'd0);
        chk("busy_before_ck", 32'(m_busy), 32'd1);
      end
      @(posedge clk);
    end
  endtask

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    sel = v.sel;
    clear_writes();
    pulse_start();
    chk("start_busy", 32'(m_busy), 32'd1);
    chk("start_ready", 32'(m_ready), 32'd1);
    chk("start_cpu_rst_f", 32'(m_cpu), 32'd0);
    chk("start_done", 32'(m_done), 32'd0);
    chk("start_err", 32'(m_err), 32'd0);
    for (int i = 0; i < v.len; i++) begin
      if (i == v.mid_start) begin
        pulse_start();
        chk("mid_start_busy", 32'(m_busy), 32'd1);
        chk("mid_start_ready", 32'(m_ready), 32'd1);
      end
      send_byte(v.b[i], (i == v.len - 1) && (v.len > 2));
      if (v.gap > 0 && i < v.len - 1) begin
        @(negedge clk);
        valid = 1'b0;
        repeat (v.gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("done", 32'(m_done), 32'(v.done));
    chk("err", 32'(m_err), 32'(!v.done));
    chk("cpu_rst_f", 32'(m_cpu), 32'(v.done));
    chk("busy_end", 32'(m_busy), 32'd0);
    chk("ready_end", 32'(m_ready), 32'd0);
    chk("write_count", 32'(wq_addr.size()), 32'(v.nw));
    if (v.nw >= 1 && wq_addr.size() >= 1) begin
      chk("waddr0", 32'(wq_addr[0]), 32'(v.a0));
      chk("wdata0", wq_data[0], v.d0);
    end
    if (v.nw >= 2 && wq_addr.size() >= 2) begin
      chk("waddr1", 32'(wq_addr[1]), 32'(v.a1));
      chk("wdata1", wq_data[1], v.d1);
      if (v.gap == 0 && v.mid_start < 0)
        chk("we_spacing", 32'(wq_cyc[1] - wq_cyc[0]), 32'd4);
    end
    $display("frame %0d: base_sel=%0d writes=%0d done=%0b err=%0b cpu_rst_f=%0b",
             idx, v.sel, wq_addr.size(), m_done, m_err, m_cpu);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready0"}, 32'(b0.BYTE_READY), 32'd0);
    chk({tag, "_we0"},    32'(b0.IM_WE), 32'd0);
    chk({tag, "_waddr0"}, 32'(b0.IM_WADDR), 32'h0000);
    chk({tag, "_waddr1"}, 32'(b1.IM_WADDR), 32'hFFFF);
    chk({tag, "_wdata0"}, b0.IM_WDATA, 32'd0);
    chk({tag, "_cpu0"},   32'(b0.CPU_RST_F), 32'd0);
    chk({tag, "_busy0"},  32'(b0.BUSY), 32'd0);
    chk({tag, "_done0"},  32'(b0.DONE), 32'd0);
    chk({tag, "_err0"},   32'(b0.ERR), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; byte_in = 8'h00; sel = 1'b0;

    // Checksums are the sum of data bytes mod 256: 12+34+..+F0 = 0x438 -> 0x38.
    vecs[0] = '{1'b0, 11, {8'h00,8'h02,8'h12,8'h34,8'h56,8'h78,8'h9A,8'hBC,8'hDE,8'hF0,8'h38},
                0, -1, 2, 16'h0000, 16'h0001, 32'h12345678, 32'h9ABCDEF0, 1'b1};
    vecs[1] = '{1'b0, 11, {8'h00,8'h02,8'h12,8'h34,8'h56,8'h78,8'h9A,8'hBC,8'hDE,8'hF0,8'h39},
                0, -1, 2, 16'h0000, 16'h0001, 32'h12345678, 32'h9ABCDEF0, 1'b0};
    vecs[2] = '{1'b0, 2, {8'h00,8'h00,72'h0}, 0, -1, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 2, {8'h04,8'h01,72'h0}, 0, -1, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 7, {8'h00,8'h01,8'hDE,8'hAD,8'hBE,8'hEF,8'h38,32'h0},
                3, -1, 1, 16'hFFFF, 16'h0, 32'hDEADBEEF, 32'h0, 1'b1};
    vecs[5] = '{1'b1, 11, {8'h00,8'h02,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h24},
                0, -1, 2, 16'hFFFF, 16'h0000, 32'h01020304, 32'h05060708, 1'b1};
    vecs[6] = '{1'b0, 7, {8'h00,8'h01,8'hAA,8'hBB,8'hCC,8'hDD,8'h0F,32'h0},
                1, -1, 1, 16'h0000, 16'h0, 32'hAABBCCDD, 32'h0, 1'b0};

    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_frame(i, vecs[i]);

    // Asynchronous reset just after the edge that accepts the 6th byte (first word's write).
    sel = 1'b0;
    clear_writes();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(vecs[0].b[i], 1'b0);
    #1 rst = 1'b1;
    #1 chk_reset("midrst");
    @(negedge clk);
    chk("midrst_no_write", 32'(wq_addr.size()), 32'd0);
    valid = 1'b0;
    rst = 1'b0;
    $display("frame mid_reset: writes=%0d busy=%0b", wq_addr.size(), m_busy);
    run_frame(7, vecs[0]);

    // Stray START in DATA is ignored; the following START in OK restarts the core reset.
    begin
      vec_t v;
      v = vecs[0];
      v.mid_start = 4;
      run_frame(8, v);
    end
    run_frame(9, vecs[5]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
